// File: rtl/match_scheduler_if.sv
// Requester-side bus of the match scheduler: word-lookup requests in, id-tagged results out.
interface match_scheduler_if #(
    parameter int NUM_REQ     = 4,
    parameter int WORD_LENGTH = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int ID_WIDTH    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]                        req_valid;
    logic [NUM_REQ*WORD_LENGTH*DATA_WIDTH-1:0] req_word;
    logic [NUM_REQ-1:0]                        req_ready;
    logic                                      rsp_valid;
    logic                                      rsp_ready;
    logic [ID_WIDTH-1:0]                       rsp_id;
    logic                                      rsp_found;
    logic                                      rsp_timeout;

    modport master (
        output req_valid, req_word, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_found, rsp_timeout
    );

    modport slave (
        input  req_valid, req_word, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_found, rsp_timeout
    );
endinterface

// File: rtl/match_scheduler.sv
// Round-robin front end for the shared vocabulary matcher: grants one requester, clears and starts
// the matcher, returns the id-tagged result. Define MATCH_TIMEOUT_EN to add the WAIT watchdog.
module match_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int WORD_LENGTH    = 3,
    parameter int DATA_WIDTH     = 8,
    parameter int ID_WIDTH       = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    match_scheduler_if.slave                  bus,
    output logic                              match_rst_n,
    output logic                              match_cs,
    output logic [WORD_LENGTH*DATA_WIDTH-1:0] match_word,
    input  logic                              match_done,
    input  logic                              match_found,
    output logic                              busy
);
    localparam int WORD_W = WORD_LENGTH * DATA_WIDTH;

    typedef enum logic [2:0] {IDLE, CLEAR, START, WAIT, RESP} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ID_WIDTH-1:0] rr_ptr;
    logic [ID_WIDTH-1:0] grant_id;
    logic                grant_vld;
    logic [WORD_W-1:0]   grant_word;
    logic                accept;
    logic                wait_timeout;
    logic                wait_exit;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        logic [ID_WIDTH-1:0] idx;
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_vld && bus.req_valid[idx]) begin
                grant_vld = 1'b1;
                grant_id  = idx;
            end
        end
    end

    always_comb begin
        grant_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_WIDTH'(i)) grant_word = bus.req_word[i*WORD_W +: WORD_W];
        end
    end

    assign accept = !rst && (state == IDLE) && grant_vld;

    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = accept && (grant_id == ID_WIDTH'(i));
        end
    end

`ifdef MATCH_TIMEOUT_EN
    logic [15:0] wait_cnt;

    // Counts WAIT cycles; zero on the first WAIT cycle of every lookup.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                wait_cnt <= '0;
        else if (state != WAIT) wait_cnt <= '0;
        else                    wait_cnt <= wait_cnt + 16'd1;
    end

    assign wait_timeout = (state == WAIT) && !match_done &&
                          (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign wait_timeout = 1'b0;
`endif

    assign wait_exit = match_done || wait_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // done seen during START is left over from the previous lookup and is ignored.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant_vld) state_nxt = CLEAR;
            CLEAR:   state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (wait_exit) state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr          <= '0;
            match_word      <= '0;
            match_rst_n     <= 1'b0;
            match_cs        <= 1'b0;
            busy            <= 1'b0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_id      <= '0;
            bus.rsp_found   <= 1'b0;
            bus.rsp_timeout <= 1'b0;
        end else begin
            match_rst_n   <= (state_nxt != CLEAR);
            match_cs      <= (state_nxt == START);
            busy          <= (state_nxt != IDLE);
            bus.rsp_valid <= (state_nxt == RESP);
            if (accept) begin
                match_word <= grant_word;
                bus.rsp_id <= grant_id;
                rr_ptr     <= (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + ID_WIDTH'(1);
            end
            if ((state == WAIT) && wait_exit) begin
                bus.rsp_found   <= match_found && !wait_timeout;
                bus.rsp_timeout <= wait_timeout;
            end
        end
    end
endmodule

// File: tb/tb_match_scheduler.sv
// Self-checking bench for match_scheduler: behavioural matcher with sticky done, round-robin reference model.
`timescale 1ns/1ps
module tb_match_scheduler;
    localparam int N  = 4;
    localparam int WL = 3;
    localparam int DW = 8;
    localparam int IW = 2;
    localparam int WW = WL * DW;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          match_rst_n, match_cs, busy;
    logic [WW-1:0] match_word;
    logic          match_done, match_found;

    int checks    = 0;
    int passes    = 0;
    int model_ptr = 0;

    logic [WW-1:0] vocab [4] = '{24'h616263, 24'h646f67, 24'h636174, 24'h7a6562};
    logic [WW-1:0] words [N];

    // Matcher model: done rises m_delay cycles after the cs cycle and stays high until cleared.
    int            m_delay = 2;
    logic          m_lazy  = 1'b0;
    logic          m_done  = 1'b0;
    logic          m_found = 1'b0;
    logic          m_busy  = 1'b0;
    int            m_cnt   = 0;
    logic [WW-1:0] m_word  = '0;

    match_scheduler_if #(.NUM_REQ(N), .WORD_LENGTH(WL), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    match_scheduler #(
        .NUM_REQ(N), .WORD_LENGTH(WL), .DATA_WIDTH(DW), .ID_WIDTH(IW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .match_rst_n(match_rst_n), .match_cs(match_cs), .match_word(match_word),
        .match_done(match_done), .match_found(match_found), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic in_vocab(input logic [WW-1:0] w);
        for (int i = 0; i < 4; i++) if (vocab[i] == w) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (match_cs && match_rst_n) begin
            m_done <= 1'b0;
            m_busy <= 1'b1;
            m_cnt  <= m_delay - 1;
            m_word <= match_word;
        end else if (!match_rst_n) begin
            if (!m_lazy) m_done <= 1'b0;
            m_busy <= 1'b0;
        end else if (m_busy) begin
            if (m_cnt <= 1) begin
                m_done  <= 1'b1;
                m_found <= in_vocab(m_word);
                m_busy  <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    assign match_done  = m_done;
    assign match_found = m_found;

    task automatic load_words();
        for (int i = 0; i < N; i++) begin
            words[i] = ($urandom_range(0, 1) == 1) ? vocab[$urandom_range(0, 3)] : WW'($urandom);
            bus.req_word[i*WW +: WW] = words[i];
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        m_lazy = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
    endtask

    // Called on the START-cycle falling edge; n = falling edges until rsp_valid, -1 if none within limit.
    task automatic wait_rsp(input int limit, output int n, output logic busy_drop, output logic cs_extra);
        n = -1;
        busy_drop = 1'b0;
        cs_extra = 1'b0;
        for (int i = 1; i <= limit && n < 0; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_drop = 1'b1;
            if (match_cs !== 1'b0) cs_extra = 1'b1;
            if (bus.rsp_valid === 1'b1) n = i;
        end
    endtask

    task automatic ack();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.req_valid = '1;
        bus.rsp_ready = 1'b0;
        load_words();
        repeat (2) @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); else passes++;
        checks++; if ({bus.rsp_valid, bus.rsp_found, bus.rsp_timeout} !== 3'b000)
            $display("FAIL reset_rsp: got %b want 000", {bus.rsp_valid, bus.rsp_found, bus.rsp_timeout}); else passes++;
        checks++; if (bus.rsp_id !== 2'd0) $display("FAIL reset_rsp_id: got %0d want 0", bus.rsp_id); else passes++;
        checks++; if ({match_rst_n, match_cs, busy} !== 3'b000)
            $display("FAIL reset_ctrl: got %b want 000", {match_rst_n, match_cs, busy}); else passes++;
        checks++; if (match_word !== '0) $display("FAIL reset_match_word: got %h want 0", match_word); else passes++;
        bus.req_valid = '0;
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({match_rst_n, busy} !== 2'b10) $display("FAIL idle_after_reset: got %b want 10", {match_rst_n, busy}); else passes++;
    endtask

    task automatic test_single();
        int n; logic bd, ce;
        bus.req_word = '0;
        bus.req_word[0 +: WW] = 24'h616263;
        m_delay = 5;
        bus.req_valid = 4'b0001;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) $display("FAIL single_grant: got %b want 0001", bus.req_ready); else passes++;
        @(negedge clk);
        bus.req_valid = '0;
        checks++; if ({match_rst_n, match_cs, busy} !== 3'b001)
            $display("FAIL single_clear: got %b want 001", {match_rst_n, match_cs, busy}); else passes++;
        @(negedge clk);
        checks++; if ({match_rst_n, match_cs, busy} !== 3'b111)
            $display("FAIL single_start: got %b want 111", {match_rst_n, match_cs, busy}); else passes++;
        checks++; if (match_word !== 24'h616263) $display("FAIL single_word: got %h want 616263", match_word); else passes++;
        wait_rsp(50, n, bd, ce);
        checks++; if (n != 6) $display("FAIL single_latency: got %0d want 6", n); else passes++;
        checks++; if ({bd, ce} !== 2'b00) $display("FAIL single_busy_cs: got %b want 00", {bd, ce}); else passes++;
        checks++; if ({bus.rsp_id, bus.rsp_found, bus.rsp_timeout} !== 4'b0010)
            $display("FAIL single_rsp: got %b want 0010", {bus.rsp_id, bus.rsp_found, bus.rsp_timeout}); else passes++;
        ack();
        checks++; if ({bus.rsp_valid, busy} !== 2'b00) $display("FAIL single_done: got %b want 00", {bus.rsp_valid, busy}); else passes++;
    endtask

    task automatic test_round_robin();
        int n; logic bd, ce;
        logic [N-1:0] exp;
        do_reset();
        load_words();
        m_delay = 2;
        bus.req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            #1;
            exp = N'(1 << (k % N));
            checks++; if (bus.req_ready !== exp) $display("FAIL rr_grant%0d: got %b want %b", k, bus.req_ready, exp); else passes++;
            @(negedge clk);
            checks++; if (bus.req_ready !== 4'b0000) $display("FAIL rr_no_grant%0d: got %b want 0000", k, bus.req_ready); else passes++;
            @(negedge clk);
            checks++; if (match_word !== words[k % N]) $display("FAIL rr_word%0d: got %h want %h", k, match_word, words[k % N]); else passes++;
            wait_rsp(50, n, bd, ce);
            checks++; if (n != 3) $display("FAIL rr_latency%0d: got %0d want 3", k, n); else passes++;
            checks++; if (bus.rsp_id !== IW'(k % N)) $display("FAIL rr_id%0d: got %0d want %0d", k, bus.rsp_id, k % N); else passes++;
            ack();
        end
        bus.req_valid = '0;
    endtask

    task automatic test_backpressure();
        int n; logic bd, ce; logic f;
        load_words();
        m_delay = 3;
        bus.req_valid = 4'b0100;
        #1;
        checks++; if (bus.req_ready !== 4'b0100) $display("FAIL bp_grant: got %b want 0100", bus.req_ready); else passes++;
        @(negedge clk);
        bus.req_valid = '1;
        @(negedge clk);
        wait_rsp(50, n, bd, ce);
        f = in_vocab(words[2]);
        checks++; if (n != 4) $display("FAIL bp_latency: got %0d want 4", n); else passes++;
        checks++; if ({bus.rsp_id, bus.rsp_found} !== {2'd2, f})
            $display("FAIL bp_rsp: got %b want %b", {bus.rsp_id, bus.rsp_found}, {2'd2, f}); else passes++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_found, bus.req_ready} !== {1'b1, 2'd2, f, 4'b0000})
                $display("FAIL bp_hold%0d: got %b want %b", i, {bus.rsp_valid, bus.rsp_id, bus.rsp_found, bus.req_ready},
                         {1'b1, 2'd2, f, 4'b0000});
            else passes++;
        end
        ack();
        #1;
        checks++; if ({bus.rsp_valid, busy} !== 2'b00) $display("FAIL bp_idle: got %b want 00", {bus.rsp_valid, busy}); else passes++;
        checks++; if (bus.req_ready !== 4'b1000) $display("FAIL bp_next_grant: got %b want 1000", bus.req_ready); else passes++;
        bus.req_valid = '0;
    endtask

    task automatic test_stale_done();
        int n; logic bd, ce;
        m_lazy = 1'b1;
        @(negedge clk);
        bus.req_word[1*WW +: WW] = 24'h000001;
        m_delay = 6;
        bus.req_valid = 4'b0010;
        #1;
        checks++; if (bus.req_ready !== 4'b0010) $display("FAIL stale_grant: got %b want 0010", bus.req_ready); else passes++;
        @(negedge clk);
        bus.req_valid = '0;
        checks++; if ({match_rst_n, match_cs} !== 2'b00) $display("FAIL stale_clear: got %b want 00", {match_rst_n, match_cs}); else passes++;
        @(negedge clk);
        checks++; if ({match_cs, bus.rsp_valid} !== 2'b10) $display("FAIL stale_start: got %b want 10", {match_cs, bus.rsp_valid}); else passes++;
        wait_rsp(50, n, bd, ce);
        checks++; if (n != 7) $display("FAIL stale_latency: got %0d want 7", n); else passes++;
        checks++; if ({bus.rsp_id, bus.rsp_found} !== 3'b010)
            $display("FAIL stale_rsp: got %b want 010", {bus.rsp_id, bus.rsp_found}); else passes++;
        ack();
        m_lazy = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        int n; logic bd, ce;
        load_words();
        m_delay = 40;
        bus.req_valid = 4'b0100;
        #1;
        checks++; if (bus.req_ready !== 4'b0100) $display("FAIL rmw_grant: got %b want 0100", bus.req_ready); else passes++;
        @(negedge clk);
        bus.req_valid = '0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if ({match_rst_n, match_cs, busy, bus.rsp_valid} !== 4'b0000)
            $display("FAIL rmw_ctrl: got %b want 0000", {match_rst_n, match_cs, busy, bus.rsp_valid}); else passes++;
        checks++; if ({match_word, bus.rsp_id} !== '0)
            $display("FAIL rmw_data: got %h/%0d want 0/0", match_word, bus.rsp_id); else passes++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_delay = 3;
        bus.req_valid = 4'b1010;
        #1;
        checks++; if (bus.req_ready !== 4'b0010) $display("FAIL rmw_ptr: got %b want 0010", bus.req_ready); else passes++;
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        wait_rsp(60, n, bd, ce);
        checks++; if (n != 4) $display("FAIL rmw_latency: got %0d want 4", n); else passes++;
        checks++; if (bus.rsp_id !== 2'd1) $display("FAIL rmw_id: got %0d want 1", bus.rsp_id); else passes++;
        ack();
    endtask

    task automatic test_timeout();
        int n; logic bd, ce;
`ifdef MATCH_TIMEOUT_EN
        for (int r = 0; r < 2; r++) begin
            bus.req_word[0 +: WW] = vocab[0];
            m_delay = (r == 0) ? 100000 : TO;
            bus.req_valid = 4'b0001;
            @(negedge clk);
            bus.req_valid = '0;
            @(negedge clk);
            wait_rsp(50, n, bd, ce);
            checks++; if (n != TO + 1) $display("FAIL to_latency%0d: got %0d want %0d", r, n, TO + 1); else passes++;
            checks++; if ({bus.rsp_timeout, bus.rsp_found} !== ((r == 0) ? 2'b10 : 2'b01))
                $display("FAIL to_rsp%0d: got %b want %b", r, {bus.rsp_timeout, bus.rsp_found}, (r == 0) ? 2'b10 : 2'b01);
            else passes++;
            ack();
        end
`else
        bus.req_word[0 +: WW] = vocab[0];
        m_delay = 100000;
        bus.req_valid = 4'b0001;
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        wait_rsp(100, n, bd, ce);
        checks++; if (n != -1) $display("FAIL wait_forever: got %0d want -1", n); else passes++;
        checks++; if ({busy, bus.rsp_timeout} !== 2'b10) $display("FAIL wait_busy: got %b want 10", {busy, bus.rsp_timeout}); else passes++;
        do_reset();
`endif
    endtask

    task automatic test_random(input int lookups);
        int n; int d; int g; logic bd, ce;
        logic [N-1:0] vld;
        do_reset();
        for (int l = 0; l < lookups; l++) begin
            repeat ($urandom_range(0, 2)) begin
                bus.req_valid = '0;
                #1;
                checks++; if (bus.req_ready !== 4'b0000) $display("FAIL rnd_idle%0d: got %b want 0000", l, bus.req_ready); else passes++;
                @(negedge clk);
            end
            vld = N'($urandom_range(1, (1 << N) - 1));
            load_words();
            d = $urandom_range(2, 6);
            m_delay = d;
            bus.req_valid = vld;
            #1;
            g = rr_pick(vld, model_ptr);
            model_ptr = (g + 1) % N;
            checks++; if (bus.req_ready !== N'(1 << g)) $display("FAIL rnd_grant%0d: got %b want %b", l, bus.req_ready, N'(1 << g)); else passes++;
            @(negedge clk);
            bus.req_valid = N'($urandom);
            @(negedge clk);
            checks++; if (match_word !== words[g]) $display("FAIL rnd_word%0d: got %h want %h", l, match_word, words[g]); else passes++;
            wait_rsp(40, n, bd, ce);
            checks++; if (n != d + 1 || bd || ce) $display("FAIL rnd_latency%0d: got %0d/%b want %0d/00", l, n, {bd, ce}, d + 1); else passes++;
            checks++;
            if ({bus.rsp_id, bus.rsp_found, bus.rsp_timeout} !== {IW'(g), in_vocab(words[g]), 1'b0})
                $display("FAIL rnd_rsp%0d: got %b want %b", l, {bus.rsp_id, bus.rsp_found, bus.rsp_timeout},
                         {IW'(g), in_vocab(words[g]), 1'b0});
            else passes++;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ack();
        end
        bus.req_valid = '0;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_word  = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_stale_done();
        test_reset_mid_wait();
        test_timeout();
        test_random(30);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1, "simulation watchdog expired");
    end
endmodule
